// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - funct codes and bus widths shared by the mul/div sequencer
package muldiv_sequencer_pkg;

    localparam int FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic is_long_op(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide step and sign fix-up
module muldiv_datapath #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              div_op,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    localparam int W2 = 2 * DATA_W;

    logic [W2-1:0]     acc;
    logic [W2-1:0]     mcand;
    logic [DATA_W-1:0] mplier;
    logic              is_div;
    logic              neg_lo;
    logic              neg_hi;

    logic              neg_a;
    logic              neg_b;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [DATA_W:0]   trial;
    logic [W2-1:0]     prod_fix;

    assign neg_a = signed_op & op_a[DATA_W-1];
    assign neg_b = signed_op & op_b[DATA_W-1];
    assign abs_a = neg_a ? -op_a : op_a;
    assign abs_b = neg_b ? -op_b : op_b;

    // Remainder is widened by the bit shifted out so the trial subtract never loses it.
    assign trial = acc[W2-1:DATA_W-1] - {1'b0, mcand[DATA_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (load) begin
            is_div <= div_op;
            neg_lo <= neg_a ^ neg_b;
            neg_hi <= div_op ? neg_a : (neg_a ^ neg_b);
            acc    <= div_op ? {{DATA_W{1'b0}}, abs_a} : '0;
            mcand  <= div_op ? {{DATA_W{1'b0}}, abs_b} : {{DATA_W{1'b0}}, abs_a};
            mplier <= abs_b;
        end else if (step) begin
            if (is_div) begin
                acc <= trial[DATA_W] ? {acc[W2-2:0], 1'b0}
                                     : {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    assign prod_fix = neg_lo ? -acc : acc;
    assign res_hi   = is_div ? (neg_hi ? -acc[W2-1:DATA_W] : acc[W2-1:DATA_W]) : prod_fix[W2-1:DATA_W];
    assign res_lo   = is_div ? (neg_lo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]) : prod_fix[DATA_W-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO owner and multi-cycle mul/div controller beside the EX ALU
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic               flush,
    output logic               stall,
    output logic               done,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
    logic              long_op;
    logic              accept;
    logic              load;
    logic              busy_iter;

    assign long_op   = is_long_op(funct);
    assign accept    = (state == S_IDLE) & start & ~flush;
    assign load      = accept & long_op;
    assign busy_iter = (state == S_MUL) | (state == S_DIV);

    // Stall from the issue cycle itself so EX holds before the FSM leaves IDLE.
    assign stall = (state != S_IDLE) | (start & long_op & (state == S_IDLE));
    assign done  = (state == S_FIX) & ~flush;

    muldiv_datapath #(.DATA_W(DATA_W)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (busy_iter & ~flush),
        .div_op    (is_div_op(funct)),
        .signed_op (is_signed_op(funct)),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            counter <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        counter <= '0;
                        state   <= is_div_op(funct) ? S_DIV : S_MUL;
                    end else if (accept && funct == FUNCT_MTHI) begin
                        hi <= op_a;
                    end else if (accept && funct == FUNCT_MTLO) begin
                        lo <= op_a;
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                        if (counter == CNT_W'(DATA_W - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench against an arithmetic HI/LO model
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h00;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    muldiv_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .funct (funct),
        .op_a  (op_a),
        .op_b  (op_b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_calc(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rh, output logic [31:0] rl);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] p;
        rh = '0;
        rl = '0;
        case (f)
            F_MULT:  begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
            F_MULTU: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
            F_DIV: begin
                if (b == 0) begin
                    rl = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                    rh = a;
                end else begin
                    p  = 64'(sa / sb); rl = p[31:0];
                    p  = 64'(sa % sb); rh = p[31:0];
                end
            end
            F_DIVU: begin
                if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
                else begin rl = a / b; rh = a % b; end
            end
            default: ;
        endcase
    endfunction

    task automatic do_long(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int flush_at);
        int          stall_cnt = 0;
        bit          seen = 0;
        bit          ended = 0;
        logic [31:0] eh, el;
        ref_calc(f, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; funct = f; op_a = a; op_b = b;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == flush_at) begin flush = 1'b1; start = 1'b0; end
            if (flush_at >= 0 && cyc == flush_at + 1) flush = 1'b0;
            #1;
            if (stall) stall_cnt++;
            if (done) begin
                check("done_cycle", 64'(cyc), 64'd33);
                check("hi_old_in_fix", {32'd0, hi}, {32'd0, model_hi});
                seen = 1; start = 1'b0; ended = 1;
                break;
            end
            if (flush_at >= 0 && cyc == flush_at + 1) begin
                check("flush_stall", {63'd0, stall}, 64'd0);
                check("flush_done", {63'd0, done}, 64'd0);
                ended = 1;
                break;
            end
        end
        if (!ended) begin
            check("timeout", 64'd0, 64'd1);
            start = 1'b0;
        end
        if (flush_at < 0 && seen) begin
            check("stall_cycles", 64'(stall_cnt), 64'd34);
            @(posedge clk); #1;
            model_hi = eh; model_lo = el;
            check("long_hi", {32'd0, hi}, {32'd0, model_hi});
            check("long_lo", {32'd0, lo}, {32'd0, model_lo});
            check("stall_after", {63'd0, stall}, 64'd0);
        end else if (flush_at >= 0) begin
            @(posedge clk); #1;
            check("flush_hi_keep", {32'd0, hi}, {32'd0, model_hi});
            check("flush_lo_keep", {32'd0, lo}, {32'd0, model_lo});
        end
    endtask

    task automatic do_short(input logic [5:0] f, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; funct = f; op_a = a; op_b = $urandom;
        #1;
        check("short_stall", {63'd0, stall}, 64'd0);
        if (f == F_MTHI) model_hi = a;
        else if (f == F_MTLO) model_lo = a;
    endtask

    task automatic settle_check();
        @(negedge clk);
        start = 1'b0;
        #1;
        check("settle_hi", {32'd0, hi}, {32'd0, model_hi});
        check("settle_lo", {32'd0, lo}, {32'd0, model_lo});
        check("settle_stall", {63'd0, stall}, 64'd0);
    endtask

    logic [5:0] rand_f [6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        do_long(F_MULT, 32'hFFFF_FFFD, 32'd7, -1);
        check("mult_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mult_neg_lo", {32'd0, lo}, 64'hFFFF_FFEB);
        do_long(F_DIVU, 32'd100, 32'd7, -1);
        check("divu_lo", {32'd0, lo}, 64'd14);
        check("divu_hi", {32'd0, hi}, 64'd2);
        do_long(F_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        check("div_neg_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        do_long(F_DIVU, 32'h1234, 32'd0, -1);
        check("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        check("div0_hi", {32'd0, hi}, 64'h1234);
        do_long(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("ovf_lo", {32'd0, lo}, 64'h8000_0000);
        check("ovf_hi", {32'd0, hi}, 64'd0);

        do_long(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
        do_long(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        check("multu_max_lo", {32'd0, lo}, 64'h1);

        do_short(F_MTHI, 32'hDEAD_BEEF);
        do_short(F_MTLO, 32'h1);
        settle_check();
        check("mthi_val", {32'd0, hi}, 64'hDEAD_BEEF);

        do_short(6'h20, 32'h5555_5555);
        settle_check();

        // flush and start together in IDLE: nothing may be latched
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; op_a = 32'h0BAD_0BAD; flush = 1'b1;
        @(negedge clk);
        funct = F_MULT;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("fs_stall", {63'd0, stall}, 64'd0);
        check("fs_hi", {32'd0, hi}, {32'd0, model_hi});

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; funct = F_DIVU; op_a = 32'd999; op_b = 32'd3;
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b1; start = 1'b0;
        #1;
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        check("arst_stall", {63'd0, stall}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        do_long(F_DIVU, 32'd999, 32'd3, -1);

        for (int i = 0; i < 20; i++) begin
            logic [5:0]  f = rand_f[$urandom_range(0, 5)];
            logic [31:0] a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            logic [31:0] b;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            if (f == F_MTHI || f == F_MTLO) begin
                do_short(f, a);
                settle_check();
            end else begin
                do_long(f, a, b, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
